// File: rtl/riscv_lsu_pkg.sv
// riscv_lsu_pkg: shared definitions for the load/store unit.
//   - RV32I load/store funct3 encodings
//   - LSU controller state type
//   - base byte-enable patterns (shifted into lane position by lsu_align)
package riscv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    localparam logic [3:0] BE_B = 4'b0001;
    localparam logic [3:0] BE_H = 4'b0011;
    localparam logic [3:0] BE_W = 4'b1111;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_align.sv
// lsu_align: combinational lane steering for the load/store unit.
// Ports:
//   funct3    in   access size/sign encoding
//   we        in   1 = store, 0 = load (stores accept only B/H/W)
//   addr      in   byte offset within the word
//   wdata     in   raw store data (rs2)
//   rdata     in   raw memory read word
//   be        out  byte enables for this access
//   wdata_rep out  store data replicated across all lanes
//   load_val  out  extracted and sign/zero-extended load value
//   misalign  out  half on odd address or word not on a 4-byte boundary
//   illegal   out  funct3 not a valid load/store encoding
module lsu_align
    import riscv_lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] load_val,
    output logic        misalign,
    output logic        illegal
);

    logic [31:0] shifted;

    assign shifted = rdata >> {addr, 3'b000};

    always_comb begin
        be        = '0;
        wdata_rep = wdata;
        load_val  = shifted;
        misalign  = 1'b0;
        illegal   = 1'b0;
        case (funct3)
            F3_B, F3_BU: begin
                illegal   = we && (funct3 == F3_BU);
                be        = BE_B << addr;
                wdata_rep = {4{wdata[7:0]}};
                load_val  = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'b0, shifted[7:0]};
            end
            F3_H, F3_HU: begin
                illegal   = we && (funct3 == F3_HU);
                misalign  = addr[0];
                be        = BE_H << {addr[1], 1'b0};
                wdata_rep = {2{wdata[15:0]}};
                load_val  = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'b0, shifted[15:0]};
            end
            F3_W: begin
                misalign  = (addr != 2'b00);
                be        = BE_W;
                wdata_rep = wdata;
                load_val  = rdata;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/riscv_lsu.sv
// riscv_lsu: load/store unit between the core datapath and data memory.
// Ports:
//   clk, rset                  clock (rising edge), async active-high reset
//   ls_valid/ls_we/ls_funct3   core request: valid, store flag, RV32I funct3
//   ls_addr/ls_wdata           byte address and store data
//   ls_rdata                   extended load result, held until next ls_done
//   ls_done                    one-cycle completion pulse
//   stall                      ls_valid & ~ls_done
//   misalign/bus_err           error flags, pulse together with ls_done
//   mem_req/dm_we              memory request and write strobe
//   MEM_addr/MEM_wDATA/mem_be  word address, lane-replicated data, byte enables
//   mem_ack/MEM_rData          memory completion and read word
module riscv_lsu
    import riscv_lsu_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              rset,
    input  logic              ls_valid,
    input  logic              ls_we,
    input  logic [2:0]        ls_funct3,
    input  logic [31:0]       ls_addr,
    input  logic [31:0]       ls_wdata,
    output logic [31:0]       ls_rdata,
    output logic              ls_done,
    output logic              stall,
    output logic              misalign,
    output logic              bus_err,
    output logic              mem_req,
    output logic [ADDR_W-1:0] MEM_addr,
    output logic [31:0]       MEM_wDATA,
    output logic [3:0]        mem_be,
    output logic              dm_we,
    input  logic              mem_ack,
    input  logic [31:0]       MEM_rData
);

    localparam int unsigned CNT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    // Count value during the last permitted WAIT cycle (counter starts at 0).
    localparam logic [CNT_W-1:0] LAST = (MAX_WAIT > 0) ? CNT_W'(MAX_WAIT - 1) : '0;

    lsu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        be_q, be_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        lo_q, lo_d;
    logic              we_q, we_d;
    logic              req_q, req_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mis_q, mis_d;
    logic              err_q, err_d;

    logic        in_range;
    logic        timeout;
    logic        idle;
    logic [2:0]  al_funct3;
    logic [1:0]  al_lo;
    logic        al_we;
    logic [3:0]  al_be;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_misalign;
    logic        al_illegal;

    assign idle     = (state_q == IDLE);
    assign in_range = ((ls_addr >> (ADDR_W + 2)) == '0);
    assign timeout  = (MAX_WAIT != 0) && (cnt_q == LAST);

    // One aligner serves both phases: live core inputs are decoded in IDLE,
    // the latched size/offset drive load extraction while waiting for ack.
    assign al_funct3 = idle ? ls_funct3    : f3_q;
    assign al_lo     = idle ? ls_addr[1:0] : lo_q;
    assign al_we     = idle ? ls_we        : we_q;

    lsu_align u_align (
        .funct3    (al_funct3),
        .we        (al_we),
        .addr      (al_lo),
        .wdata     (ls_wdata),
        .rdata     (MEM_rData),
        .be        (al_be),
        .wdata_rep (al_wdata),
        .load_val  (al_load),
        .misalign  (al_misalign),
        .illegal   (al_illegal)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        f3_d    = f3_q;
        lo_d    = lo_q;
        we_d    = we_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        mis_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ls_valid) begin
                    if (al_illegal) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else if (al_misalign) begin
                        state_d = DONE;
                        mis_d   = 1'b1;
                        rdata_d = '0;
                    end else if (!in_range) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        addr_d  = ls_addr[ADDR_W+1:2];
                        wdata_d = al_wdata;
                        be_d    = al_be;
                        f3_d    = ls_funct3;
                        lo_d    = ls_addr[1:0];
                        we_d    = ls_we;
                        req_d   = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = al_load;
                    end
                end else if (timeout) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rset) begin
        if (rset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
            we_q    <= 1'b0;
            req_q   <= 1'b0;
            rdata_q <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            f3_q    <= f3_d;
            lo_q    <= lo_d;
            we_q    <= we_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
        end
    end

    assign ls_done   = (state_q == DONE);
    assign stall     = ls_valid & ~ls_done;
    assign misalign  = mis_q;
    assign bus_err   = err_q;
    assign ls_rdata  = rdata_q;
    assign mem_req   = req_q;
    assign MEM_addr  = addr_q;
    assign MEM_wDATA = wdata_q;
    assign mem_be    = be_q;
    assign dm_we     = req_q & we_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// tb_riscv_lsu: directed and randomized checks of riscv_lsu against a
// behavioural transaction model (sizes, lanes and extension computed with
// plain arithmetic; latency derived from the handshake rules).
module tb_riscv_lsu;

    localparam int TB_ADDR_W   = 8;
    localparam int TB_MAX_WAIT = 15;
    localparam int LIMIT       = 40;

    logic                 clk = 1'b0;
    logic                 rset;
    logic                 ls_valid;
    logic                 ls_we;
    logic [2:0]           ls_funct3;
    logic [31:0]          ls_addr;
    logic [31:0]          ls_wdata;
    logic [31:0]          ls_rdata;
    logic                 ls_done;
    logic                 stall;
    logic                 misalign;
    logic                 bus_err;
    logic                 mem_req;
    logic [TB_ADDR_W-1:0] MEM_addr;
    logic [31:0]          MEM_wDATA;
    logic [3:0]           mem_be;
    logic                 dm_we;
    logic                 mem_ack;
    logic [31:0]          MEM_rData;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] last_rdata = '0;

    riscv_lsu #(.ADDR_W(TB_ADDR_W), .MAX_WAIT(TB_MAX_WAIT)) dut (
        .clk       (clk),
        .rset      (rset),
        .ls_valid  (ls_valid),
        .ls_we     (ls_we),
        .ls_funct3 (ls_funct3),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_rdata  (ls_rdata),
        .ls_done   (ls_done),
        .stall     (stall),
        .misalign  (misalign),
        .bus_err   (bus_err),
        .mem_req   (mem_req),
        .MEM_addr  (MEM_addr),
        .MEM_wDATA (MEM_wDATA),
        .mem_be    (mem_be),
        .dm_we     (dm_we),
        .mem_ack   (mem_ack),
        .MEM_rData (MEM_rData)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [31:0] addr,
                                               input logic [31:0] w);
        longint v;
        int     bits;
        bits = 8 * (1 << f3[1:0]);
        v = longint'({32'd0, w >> (8 * (addr % 4))});
        if (bits < 32) begin
            v = v % (longint'(1) << bits);
            if (!f3[2] && v >= (longint'(1) << (bits - 1)))
                v = v - (longint'(1) << bits);
        end
        return v[31:0];
    endfunction

    // ack_wait = number of WAIT cycles before the ack cycle (large = never)
    task automatic run_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rword,
                           input int ack_wait, input bit drop);
        bit          legal, mis, rng, ok, tmo, e_err, seen;
        int          size, lat, c, done_c, stall_n, req_n, we_n, e_stall;
        logic [31:0] e_rd, e_wd, e_be, e_ad;
        size  = 1 << f3[1:0];
        legal = we ? (f3 <= 3'd2) : (f3 != 3'd3 && f3 != 3'd6 && f3 != 3'd7);
        mis   = legal && ((addr % size) != 0);
        rng   = (addr < (32'd1 << (TB_ADDR_W + 2)));
        ok    = legal && !mis && rng;
        tmo   = 1'b0;
        if (!ok) lat = 1;
        else if (ack_wait + 1 > TB_MAX_WAIT) begin lat = TB_MAX_WAIT + 1; tmo = 1'b1; end
        else lat = ack_wait + 2;
        e_err = !legal || (legal && !mis && !rng) || tmo;
        if (!ok || tmo) e_rd = '0;
        else if (we) e_rd = last_rdata;
        else e_rd = load_model(f3, addr, rword);
        e_be = 32'(((1 << size) - 1) << (addr % 4));
        e_ad = (addr / 4) % (32'd1 << TB_ADDR_W);
        if (size == 1) e_wd = (wdata & 32'hFF) * 32'h01010101;
        else if (size == 2) e_wd = (wdata & 32'hFFFF) * 32'h00010001;
        else e_wd = wdata;
        e_stall = drop ? ((lat >= 2) ? 2 : 1) : lat;

        @(negedge clk);
        check_eq("pre_done", 32'(ls_done), 32'd0);
        check_eq("pre_req", 32'(mem_req), 32'd0);
        check_eq("hold_rdata", ls_rdata, last_rdata);
        ls_valid = 1'b1; ls_we = we; ls_funct3 = f3; ls_addr = addr;
        ls_wdata = wdata; MEM_rData = rword; mem_ack = 1'b0;
        #1;
        stall_n = stall ? 1 : 0;
        req_n = 0; we_n = 0; done_c = 0; seen = 1'b0;
        for (c = 1; c <= LIMIT; c++) begin
            @(negedge clk);
            if (stall) stall_n++;
            if (dm_we) we_n++;
            if (mem_req) begin
                req_n++;
                check_eq("mem_addr", 32'(MEM_addr), e_ad);
                check_eq("mem_be", 32'(mem_be), e_be);
                if (we) check_eq("mem_wdata", MEM_wDATA, e_wd);
            end
            if (ls_done) begin
                done_c = c; seen = 1'b1;
                check_eq("misalign", 32'(misalign), 32'(mis));
                check_eq("bus_err", 32'(bus_err), 32'(e_err));
                check_eq("ls_rdata", ls_rdata, e_rd);
                break;
            end
            mem_ack = ok && (c == ack_wait + 1);
            if (drop && c == 1) ls_valid = 1'b0;
        end
        ls_valid = 1'b0; mem_ack = 1'b0;
        check_eq("done_seen", 32'(seen), 32'd1);
        check_eq("latency", 32'(done_c), 32'(lat));
        check_eq("req_cycles", 32'(req_n), ok ? 32'(lat - 1) : 32'd0);
        check_eq("we_cycles", 32'(we_n), (ok && we) ? 32'(lat - 1) : 32'd0);
        check_eq("stall_cycles", 32'(stall_n), 32'(e_stall));
        if (seen) last_rdata = e_rd;
        @(negedge clk);
        check_eq("done_pulse", 32'(ls_done), 32'd0);
    endtask

    task automatic reset_in_wait();
        @(negedge clk);
        ls_valid = 1'b1; ls_we = 1'b0; ls_funct3 = 3'd2; ls_addr = 32'h20;
        ls_wdata = '0; MEM_rData = 32'h12345678; mem_ack = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_pre_req", 32'(mem_req), 32'd1);
        #2 rset = 1'b1;
        #1;
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_dm_we", 32'(dm_we), 32'd0);
        check_eq("rst_done", 32'(ls_done), 32'd0);
        check_eq("rst_rdata", ls_rdata, 32'd0);
        check_eq("rst_be", 32'(mem_be), 32'd0);
        ls_valid = 1'b0;
        @(negedge clk);
        rset = 1'b0;
        last_rdata = '0;
        @(negedge clk);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("late_ack_done", 32'(ls_done), 32'd0);
            check_eq("late_ack_req", 32'(mem_req), 32'd0);
        end
        check_eq("late_ack_rdata", ls_rdata, 32'd0);
    endtask

    initial begin
        rset = 1'b1; ls_valid = 1'b0; ls_we = 1'b0; ls_funct3 = '0;
        ls_addr = '0; ls_wdata = '0; mem_ack = 1'b0; MEM_rData = '0;
        #1;
        check_eq("reset_req", 32'(mem_req), 32'd0);
        check_eq("reset_done", 32'(ls_done), 32'd0);
        check_eq("reset_rdata", ls_rdata, 32'd0);
        check_eq("reset_flags", 32'({misalign, bus_err, dm_we}), 32'd0);
        repeat (2) @(negedge clk);
        rset = 1'b0;

        run_txn(1'b0, 3'd2, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1'b0);
        run_txn(1'b0, 3'd0, 32'h13, 32'h0, 32'h80FF1234, 0, 1'b0);
        run_txn(1'b0, 3'd4, 32'h13, 32'h0, 32'h80FF1234, 1, 1'b0);
        run_txn(1'b1, 3'd1, 32'h22, 32'h0000ABCD, 32'h0, 3, 1'b0);
        run_txn(1'b0, 3'd2, 32'h06, 32'h0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 3'd1, 32'h400, 32'h0, 32'h0, 0, 1'b0);
        run_txn(1'b0, 3'd2, 32'h44, 32'h0, 32'hCAFEF00D, 99, 1'b0);
        run_txn(1'b0, 3'd5, 32'h3E, 32'h0, 32'h9ABC0000, 14, 1'b0);
        run_txn(1'b1, 3'd4, 32'h08, 32'h11, 32'h0, 0, 1'b0);
        run_txn(1'b0, 3'd1, 32'h12, 32'h0, 32'h8001ABCD, 2, 1'b1);
        run_txn(1'b1, 3'd2, 32'h3FC, 32'hA5A55A5A, 32'h0, 0, 1'b0);
        reset_in_wait();

        for (int n = 0; n < 60; n++) begin
            logic        we;
            logic [2:0]  f3;
            logic [31:0] addr;
            int          r, aw;
            we   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 1023);
            r    = int'($urandom_range(0, 9));
            if (r < 7) aw = int'($urandom_range(0, 3));
            else if (r == 7) aw = 14;
            else if (r == 8) aw = 15;
            else aw = 99;
            run_txn(we, f3, addr, $urandom, $urandom, aw, $urandom_range(0, 4) == 0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Parametrised load/store unit between the core datapath and data memory. It replaces the single-cycle, word-only, fixed 8-bit-address memory path. It adds byte/half/word accesses with sign or zero extension, byte enables, and misalignment and range checking. Memory latency is handled by a req/ack handshake with a stall output to the core and a wait-state timeout.

Parameters:
ADDR_W, 8, word-address width driven on MEM_addr; byte address space is 2^(ADDR_W+2).
MAX_WAIT, 15, max cycles in WAIT without mem_ack before bus error; 0 disables timeout.

Ports:
clk  in  1  clock, rising edge
rset  in  1  asynchronous active-high reset
ls_valid  in  1  core presents a load/store this cycle
ls_we  in  1  1=store, 0=load
ls_funct3  in  3  RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
ls_addr  in  32  byte address (ALU result)
ls_wdata  in  32  store data (rs2)
ls_rdata  out  32  extended load result, registered, held until next ls_done
ls_done  out  1  one-cycle completion pulse
stall  out  1  combinational: ls_valid & ~ls_done
misalign  out  1  pulses with ls_done on misaligned access
bus_err  out  1  pulses with ls_done on illegal funct3, out-of-range address or timeout
mem_req  out  1  memory request, registered
MEM_addr  out  ADDR_W  word address = ls_addr[ADDR_W+1:2]
MEM_wDATA  out  32  lane-replicated store data
mem_be  out  4  byte enables
dm_we  out  1  mem_req & store
mem_ack  in  1  memory done; read data valid this cycle
MEM_rData  in  32  memory read word

Behaviour:
- Reset (async, rset=1):
  - State goes to IDLE and the wait counter clears.
  - All outputs go to 0 immediately, including mem_req and dm_we.
  - A late mem_ack seen after reset is ignored.
- FSM states: IDLE, WAIT, DONE.
- IDLE, ls_valid=1: decode, then one of:
  - illegal funct3 (3, 6, 7 for loads; anything other than 0–2 for stores): go DONE, bus_err=1, no request.
  - misaligned (half with addr[0]=1; word with addr[1:0]≠0): go DONE, misalign=1, no request.
  - ls_addr[31:ADDR_W+2]≠0: go DONE, bus_err=1, no request.
  - otherwise: latch address, lanes, be, funct3 and we; set mem_req=1; go WAIT.
  - misalign takes priority over the range bus_err.
- WAIT:
  - mem_req and all memory outputs stay stable; the counter increments each cycle.
  - mem_ack=1: capture the extracted load value into ls_rdata (loads only; stores leave it unchanged), drop mem_req, go DONE.
  - Timeout: counter reaches MAX_WAIT with no ack → drop mem_req, ls_rdata=0, bus_err=1, go DONE.
  - mem_ack and timeout in the same cycle: ack wins.
  - ls_valid falling during WAIT does not abort; the transaction completes.
- DONE:
  - ls_done=1 for exactly one cycle, then unconditionally IDLE.
  - No re-accept is possible in DONE.
  - On error completions ls_rdata=0.
- Latency from accept edge: ack in first WAIT cycle → ls_done 2 cycles later; each wait state adds 1; error/misalign paths give ls_done 1 cycle after accept.
- Store lanes:
  - SB: MEM_wDATA={4{b}}, be=0001<<addr[1:0].
  - SH: {2{h}}, be=0011<<{addr[1],1'b0}.
  - SW: word, be=1111.
  - Loads drive the same be.
- Load extract:
  - MEM_rData>>(8*addr[1:0]).
  - LB sign-extends bit 7; LBU zero-extends.
  - LH sign-extends bit 15; LHU zero-extends.
  - LW passes the word unchanged.
- Counter width: clog2(MAX_WAIT+1), no wrap; it clears on entering WAIT.

Decomposition:
- riscv_pkg:
  - funct3 constants F3_B/F3_H/F3_W/F3_BU/F3_HU.
  - lsu_state_t enum (IDLE/WAIT/DONE).
  - Byte-enable constants.
- Sub-module lsu_align: purely combinational.
  - Inputs: funct3, addr[1:0], wdata, rdata.
  - Outputs: be, replicated wdata, extended load value, misalign flag, illegal flag.
  - The FSM lives in riscv_lsu.

Test Plan:
- LW at 0x10, MEM_rData=0xDEADBEEF, ack on first WAIT cycle → MEM_addr=0x04, be=1111, ls_done 2 cycles after accept, ls_rdata=0xDEADBEEF, stall high exactly 2 cycles.
- LB at 0x13 and LBU at 0x13 with MEM_rData=0x80FF1234 → ls_rdata=0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x22, ls_wdata=0x0000ABCD, ack after 3 wait states → MEM_wDATA=0xABCDABCD, be=1100, dm_we high 4 cycles, ls_done 5 cycles after accept.
- LW at 0x06 → no mem_req, misalign=1 with ls_done 1 cycle after accept; LH at 0x400 (ADDR_W=8) → bus_err=1, no mem_req.
- MAX_WAIT=15, never ack → mem_req drops after 15 WAIT cycles, bus_err=1, ls_rdata=0; repeat with ack on cycle 15 → ack wins, bus_err=0.
- Assert rset during WAIT, then pulse mem_ack after release → mem_req=0 immediately, state IDLE, no ls_done, ls_rdata unchanged at 0.
